// File: rtl/fast_square_sweep_sequencer.sv
// Programmable sweep scheduler for the fast-square receive path: settings-bus
// configured step count and dwell lengths, driving synth step and rx sequencing.
module fast_square_sweep_sequencer #(
    parameter logic [6:0]  BASE_ADDR  = 7'd80,
    parameter int unsigned MAX_STEPS  = 32,
    parameter int unsigned STEP_IDX_W = 5,
    parameter int unsigned PULSE_LEN  = 4,
    parameter logic [15:0] DEF_SETTLE = 16'd0,
    parameter logic [15:0] DEF_RECORD = 16'd35000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  serial_strobe,
    input  logic [6:0]            serial_addr,
    input  logic [31:0]           serial_data,
    input  logic                  trigger,
    output logic                  freq_step,
    output logic                  rx_reset,
    output logic                  rx_next,
    output logic                  rx_record,
    output logic                  busy,
    output logic [STEP_IDX_W-1:0] step_index,
    output logic [15:0]           sweep_count
);

    localparam int unsigned NUM_W   = STEP_IDX_W + 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FIELD_W = 6;
    localparam int unsigned SC_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_STEP,
        S_SETTLE,
        S_RECORD,
        S_NEXT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic                  trig_s1_q, trig_s1_d;
    logic                  trig_s2_q, trig_s2_d;
    logic                  trig_s3_q, trig_s3_d;
    logic                  trig_edge_q, trig_edge_d;

    logic                  enable_q, enable_d;
    logic                  continuous_q, continuous_d;
    logic [NUM_W-1:0]      num_steps_q, num_steps_d;
    logic [15:0]           settle_ticks_q, settle_ticks_d;
    logic [15:0]           record_ticks_q, record_ticks_d;

    logic [NUM_W-1:0]      n_latched_q, n_latched_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STEP_IDX_W-1:0] step_index_q, step_index_d;
    logic [SC_W-1:0]       sweep_count_q, sweep_count_d;

    logic                  freq_step_q, freq_step_d;
    logic                  rx_reset_q, rx_reset_d;
    logic                  rx_next_q, rx_next_d;
    logic                  rx_record_q, rx_record_d;
    logic                  busy_q, busy_d;

    logic                  wr_ctrl_c, wr_num_c, wr_settle_c, wr_record_c;
    logic                  abort_c;
    logic [FIELD_W-1:0]    num_field_c;
    logic [CNT_W-1:0]      settle_load_c, record_load_c;
    logic                  last_step_c;
    logic                  unused_data_c;

    assign unused_data_c = ^serial_data[31:16];

    // Trigger synchronizer and registered rising-edge detect
    always_comb begin
        trig_s1_d   = trigger;
        trig_s2_d   = trig_s1_q;
        trig_s3_d   = trig_s2_q;
        trig_edge_d = trig_s2_q & ~trig_s3_q;
    end

    // Settings-bus register writes; num_steps clamps to MAX_STEPS on write
    always_comb begin
        wr_ctrl_c   = serial_strobe && (serial_addr == BASE_ADDR);
        wr_num_c    = serial_strobe && (serial_addr == BASE_ADDR + 7'd1);
        wr_settle_c = serial_strobe && (serial_addr == BASE_ADDR + 7'd2);
        wr_record_c = serial_strobe && (serial_addr == BASE_ADDR + 7'd3);
        num_field_c = serial_data[FIELD_W-1:0];
        abort_c     = wr_ctrl_c && !serial_data[0];

        enable_d       = enable_q;
        continuous_d   = continuous_q;
        num_steps_d    = num_steps_q;
        settle_ticks_d = settle_ticks_q;
        record_ticks_d = record_ticks_q;

        if (wr_ctrl_c) begin
            enable_d     = serial_data[0];
            continuous_d = serial_data[1];
        end
        if (wr_num_c) begin
            if (num_field_c == '0 || 32'(num_field_c) > MAX_STEPS) begin
                num_steps_d = NUM_W'(MAX_STEPS);
            end else begin
                num_steps_d = NUM_W'(num_field_c);
            end
        end
        if (wr_settle_c) begin
            settle_ticks_d = serial_data[15:0];
        end
        if (wr_record_c) begin
            record_ticks_d = serial_data[15:0];
        end
    end

    // Dwell loads are max(ticks,1)-1 so a zero setting still gives one cycle
    always_comb begin
        settle_load_c = (settle_ticks_q == '0) ? '0 : settle_ticks_q - CNT_W'(1);
        record_load_c = (record_ticks_q == '0) ? '0 : record_ticks_q - CNT_W'(1);
        last_step_c   = (step_index_q == STEP_IDX_W'(n_latched_q - NUM_W'(1)));
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        step_index_d  = step_index_q;
        n_latched_d   = n_latched_q;
        sweep_count_d = sweep_count_q;

        case (state_q)
            S_IDLE: begin
                if (trig_edge_q && enable_d) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                n_latched_d  = num_steps_q;
                step_index_d = '0;
                cnt_d        = CNT_W'(PULSE_LEN - 1);
                state_d      = S_STEP;
            end
            S_STEP: begin
                if (cnt_q == '0) begin
                    cnt_d   = settle_load_c;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = record_load_c;
                    state_d = S_RECORD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RECORD: begin
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (last_step_c) begin
                    state_d = S_DONE;
                end else begin
                    step_index_d = step_index_q + STEP_IDX_W'(1);
                    cnt_d        = CNT_W'(PULSE_LEN - 1);
                    state_d      = S_STEP;
                end
            end
            S_DONE: begin
                sweep_count_d = sweep_count_q + SC_W'(1);
                state_d       = (continuous_d && enable_d) ? S_RESET : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable write aborts from any state, freezing step and sweep counts
        if (abort_c) begin
            state_d       = S_IDLE;
            cnt_d         = cnt_q;
            step_index_d  = step_index_q;
            n_latched_d   = n_latched_q;
            sweep_count_d = sweep_count_q;
        end

        freq_step_d = (state_d == S_STEP);
        rx_reset_d  = (state_d == S_RESET);
        rx_next_d   = (state_d == S_NEXT);
        rx_record_d = (state_d == S_RECORD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            trig_s1_q      <= 1'b0;
            trig_s2_q      <= 1'b0;
            trig_s3_q      <= 1'b0;
            trig_edge_q    <= 1'b0;
            enable_q       <= 1'b0;
            continuous_q   <= 1'b0;
            num_steps_q    <= NUM_W'(MAX_STEPS);
            settle_ticks_q <= DEF_SETTLE;
            record_ticks_q <= DEF_RECORD;
            n_latched_q    <= NUM_W'(MAX_STEPS);
            cnt_q          <= '0;
            step_index_q   <= '0;
            sweep_count_q  <= '0;
            freq_step_q    <= 1'b0;
            rx_reset_q     <= 1'b0;
            rx_next_q      <= 1'b0;
            rx_record_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_s1_q      <= trig_s1_d;
            trig_s2_q      <= trig_s2_d;
            trig_s3_q      <= trig_s3_d;
            trig_edge_q    <= trig_edge_d;
            enable_q       <= enable_d;
            continuous_q   <= continuous_d;
            num_steps_q    <= num_steps_d;
            settle_ticks_q <= settle_ticks_d;
            record_ticks_q <= record_ticks_d;
            n_latched_q    <= n_latched_d;
            cnt_q          <= cnt_d;
            step_index_q   <= step_index_d;
            sweep_count_q  <= sweep_count_d;
            freq_step_q    <= freq_step_d;
            rx_reset_q     <= rx_reset_d;
            rx_next_q      <= rx_next_d;
            rx_record_q    <= rx_record_d;
            busy_q         <= busy_d;
        end
    end

    assign freq_step   = freq_step_q;
    assign rx_reset    = rx_reset_q;
    assign rx_next     = rx_next_q;
    assign rx_record   = rx_record_q;
    assign busy        = busy_q;
    assign step_index  = step_index_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_fast_square_sweep_sequencer.sv
// Scoreboard bench: a sweep-level model queues expected events, a monitor
// reconstructs events from the DUT outputs and compares them in order.
module tb_fast_square_sweep_sequencer;

    localparam int P    = 4;
    localparam int MAXN = 32;
    localparam int EV_RST = 1, EV_NEXT = 2, EV_DONE = 3, EV_IDLE = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    logic        clock;
    logic        reset_n;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        trigger;
    logic        freq_step, rx_reset, rx_next, rx_record, busy;
    logic [4:0]  step_index;
    logic [15:0] sweep_count;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   trig_cyc = 0;
    int   model_sc = 0;
    ev_t  exp_q[$];

    fast_square_sweep_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .serial_strobe(serial_strobe),
        .serial_addr  (serial_addr),
        .serial_data  (serial_data),
        .trigger      (trigger),
        .freq_step    (freq_step),
        .rx_reset     (rx_reset),
        .rx_next      (rx_next),
        .rx_record    (rx_record),
        .busy         (busy),
        .step_index   (step_index),
        .sweep_count  (sweep_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic ev_t mk(input int k, input int a, input int b, input int c, input int d);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        return e;
    endfunction

    function automatic int mx1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int clampn(input int v);
        return (v == 0 || v > MAXN) ? MAXN : v;
    endfunction

    // Reference: whole sweeps described as event lists from dwell arithmetic
    task automatic model_sweeps(input int n_raw, input int s, input int r, input int sweeps,
                                input bit from_idle, input bit end_idle);
        int n, step_len;
        n = clampn(n_raw);
        step_len = P + mx1(s) + mx1(r) + 1;
        for (int j = 0; j < sweeps; j++) begin
            exp_q.push_back(mk(EV_RST, (j == 0 && from_idle) ? 3 : 0, 0, 0, 0));
            for (int i = 0; i < n; i++) exp_q.push_back(mk(EV_NEXT, i, P, mx1(s), mx1(r)));
            model_sc = (model_sc + 1) % 65536;
            exp_q.push_back(mk(EV_DONE, model_sc, 2 + n * step_len, 0, 0));
        end
        if (end_idle) exp_q.push_back(mk(EV_IDLE, model_sc, 0, 0, 0));
    endtask

    task automatic check_ev(input ev_t got);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event got kind=%0d a=%0d b=%0d c=%0d d=%0d, expected none",
                     got.kind, got.a, got.b, got.c, got.d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != got.kind || e.a != got.a || e.b != got.b || e.c != got.c || e.d != got.d) begin
                mismatched++;
                $display("FAIL event got kind=%0d a=%0d b=%0d c=%0d d=%0d, expected kind=%0d a=%0d b=%0d c=%0d d=%0d",
                         got.kind, got.a, got.b, got.c, got.d, e.kind, e.a, e.b, e.c, e.d);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: rebuild events from output waveforms, sampled on the falling edge
    int  m_pc = 0, m_sc = 0, m_rc = 0;
    int  m_rst_cyc = 0, m_done_cyc = 0;
    bit  m_prev_busy = 0, m_prev_rec = 0;
    int  m_prev_sweep = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_prev_busy = 0; m_prev_rec = 0; m_prev_sweep = 0;
            m_pc = 0; m_sc = 0; m_rc = 0;
        end else begin
            if (int'(sweep_count) != m_prev_sweep) begin
                check_ev(mk(EV_DONE, int'(sweep_count), cyc - m_rst_cyc, 0, 0));
                m_done_cyc = cyc;
            end
            if (m_prev_busy && !busy) check_ev(mk(EV_IDLE, int'(sweep_count), 0, 0, 0));
            if (rx_reset) begin
                check_ev(mk(EV_RST, m_prev_busy ? cyc - m_done_cyc : cyc - trig_cyc, 0, 0, 0));
                m_rst_cyc = cyc;
                m_pc = 0; m_sc = 0; m_rc = 0;
            end
            if (freq_step) begin
                m_pc++;
                compared++;
                if (rx_record) begin
                    mismatched++;
                    $display("FAIL step_record_overlap got rx_record=1 expected 0 at cycle %0d", cyc);
                end
            end
            if (rx_record) m_rc++;
            if (busy && !freq_step && !rx_record && !rx_reset && !rx_next && m_pc > 0 && m_rc == 0) m_sc++;
            if (rx_next) begin
                check_ev(mk(EV_NEXT, int'(step_index), m_pc, m_sc, m_rc));
                chk("record_falls_with_next", int'(m_prev_rec && !rx_record), 1);
                m_pc = 0; m_sc = 0; m_rc = 0;
            end
            m_prev_busy = busy;
            m_prev_rec = rx_record;
            m_prev_sweep = int'(sweep_count);
        end
    end

    function automatic bit probe(input int w);
        case (w)
            0: return !busy;
            1: return busy;
            2: return freq_step;
            3: return !freq_step;
            4: return rx_next;
            5: return (int'(sweep_count) == model_sc) && (step_index == 5'd1) && rx_record;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, input string name);
        int n = 0;
        while (!probe(w) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!probe(w)) begin
            compared++;
            mismatched++;
            $display("FAIL timeout_%s got no event within %0d cycles expected event", name, budget);
        end
    endtask

    task automatic wr(input int off, input int val);
        serial_strobe = 1'b1;
        serial_addr   = 7'(80 + off);
        serial_data   = 32'(val);
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    task automatic trig(input bit note);
        trigger = 1'b1;
        if (note) trig_cyc = cyc + 1;
        @(negedge clock);
        @(negedge clock);
        trigger = 1'b0;
    endtask

    task automatic run_sweep(input int budget, input string name);
        trig(1'b1);
        wait_for(1, 10, {name, "_start"});
        wait_for(0, budget, {name, "_end"});
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_freq_step"}, int'(freq_step), 0);
        chk({tag, "_rx_reset"}, int'(rx_reset), 0);
        chk({tag, "_rx_next"}, int'(rx_next), 0);
        chk({tag, "_rx_record"}, int'(rx_record), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_step_index"}, int'(step_index), 0);
        chk({tag, "_sweep_count"}, int'(sweep_count), 0);
    endtask

    initial begin
        int s, r, n;
        reset_n = 1'b0; serial_strobe = 1'b0; serial_addr = '0; serial_data = '0; trigger = 1'b0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Defaults: settle 0 -> 1 cycle, record 35000; abort after the first step
        exp_q.push_back(mk(EV_RST, 3, 0, 0, 0));
        exp_q.push_back(mk(EV_NEXT, 0, P, 1, 35000));
        exp_q.push_back(mk(EV_IDLE, 0, 0, 0, 0));
        wr(0, 1);
        trig(1'b1);
        wait_for(4, 36000, "default_next");
        wr(0, 0);
        chk("default_abort_busy", int'(busy), 0);
        chk("default_abort_step_hold", int'(step_index), 0);
        repeat (3) @(negedge clock);

        // Default step count with zero dwell windows
        wr(2, 0); wr(3, 0); wr(0, 1);
        model_sweeps(MAXN, 0, 0, 1, 1'b1, 1'b1);
        run_sweep(400, "default_n");

        // Single sweep with an extra trigger mid-sweep that must be ignored
        wr(1, 3); wr(2, 2); wr(3, 5);
        model_sweeps(3, 2, 5, 1, 1'b1, 1'b1);
        trig(1'b1);
        wait_for(2, 10, "single_step");
        trig(1'b0);
        wait_for(0, 100, "single_end");
        repeat (3) @(negedge clock);

        // Clamp of num_steps: 0 and above-range, zero dwell
        wr(1, 0); wr(2, 0); wr(3, 0);
        model_sweeps(0, 0, 0, 1, 1'b1, 1'b1);
        run_sweep(400, "clamp0");
        wr(1, 40);
        model_sweeps(40, 0, 0, 1, 1'b1, 1'b1);
        run_sweep(400, "clamp40");

        // Random short sweeps
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 5)); s = int'($urandom_range(0, 6)); r = int'($urandom_range(0, 8));
            wr(1, n); wr(2, s); wr(3, r);
            model_sweeps(n, s, r, 1, 1'b1, 1'b1);
            run_sweep(400, "random");
        end

        // Trigger while disabled produces nothing
        wr(0, 0);
        trig(1'b1);
        repeat (20) @(negedge clock);
        chk("disabled_trigger_busy", int'(busy), 0);

        // Enable write in the same cycle the trigger edge is seen
        wr(1, 1); wr(2, 1); wr(3, 1);
        model_sweeps(1, 1, 1, 1, 1'b1, 1'b1);
        trigger = 1'b1;
        trig_cyc = cyc + 1;
        @(negedge clock);
        @(negedge clock);
        trigger = 1'b0;
        @(negedge clock);
        wr(0, 1);
        wait_for(0, 100, "same_cycle_end");
        repeat (3) @(negedge clock);

        // Continuous mode, then abort during the second record of the third sweep
        wr(1, 2); wr(2, 1); wr(3, 3);
        model_sweeps(2, 1, 3, 2, 1'b1, 1'b0);
        exp_q.push_back(mk(EV_RST, 0, 0, 0, 0));
        exp_q.push_back(mk(EV_NEXT, 0, P, 1, 3));
        exp_q.push_back(mk(EV_IDLE, model_sc, 0, 0, 0));
        wr(0, 3);
        trig(1'b1);
        wait_for(5, 200, "cont_third_record");
        wr(0, 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rx_record", int'(rx_record), 0);
        chk("abort_step_hold", int'(step_index), 1);
        chk("abort_sweep_count", int'(sweep_count), model_sc);
        repeat (3) @(negedge clock);

        // Asynchronous reset during settle, then a fresh sweep from step 0
        wr(1, 3); wr(2, 20); wr(3, 5); wr(0, 1);
        exp_q.push_back(mk(EV_RST, 3, 0, 0, 0));
        trig(1'b1);
        wait_for(2, 10, "areset_step");
        wait_for(3, 10, "areset_settle");
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        model_sc = 0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        wr(1, 2); wr(2, 1); wr(3, 2); wr(0, 1);
        model_sweeps(2, 1, 2, 1, 1'b1, 1'b1);
        run_sweep(100, "after_reset");

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
